muldiv_writeback_unit: RTL and testbench



---
 rtl/muldiv_pkg.sv | 18 +
 rtl/muldiv_writeback_unit_if.sv | 25 ++
 rtl/muldiv_step_core.sv | 37 +++
 rtl/muldiv_writeback_unit.sv | 137 +++++++++++++
 tb/tb_muldiv_writeback_unit.sv | 140 ++++++++++++++
 5 files changed

// File: rtl/muldiv_pkg.sv
// Shared widths, op encodings and FSM states for the iterative mul/div writeback unit.
package muldiv_pkg;

   localparam int unsigned XLEN = 16;
   localparam int unsigned AW   = 4;
   localparam int unsigned ITER = 16;

   localparam logic [1:0] OP_MUL  = 2'b00;
   localparam logic [1:0] OP_MULH = 2'b01;
   localparam logic [1:0] OP_DIV  = 2'b10;
   localparam logic [1:0] OP_REM  = 2'b11;
   localparam int unsigned OP_SIGNED_BIT = 2;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   localparam logic [XLEN-1:0] DIV0_QUOTIENT = 16'hFFFF;

endpackage

// File: rtl/muldiv_writeback_unit_if.sv
// Operand/request and writeback bundle between decoder/register_file and the mul/div unit.
interface muldiv_writeback_unit_if import muldiv_pkg::*; ();

   logic            start;
   logic [2:0]      op;
   logic [XLEN-1:0] rs1_data;
   logic [XLEN-1:0] rs2_data;
   logic [AW-1:0]   rd;
   logic            stall;
   logic            busy;
   logic            rf_we;
   logic [AW-1:0]   rf_waddr;
   logic [XLEN-1:0] rf_wdata;

   modport master (
      output start, op, rs1_data, rs2_data, rd,
      input  stall, busy, rf_we, rf_waddr, rf_wdata
   );

   modport slave (
      input  start, op, rs1_data, rs2_data, rd,
      output stall, busy, rf_we, rf_waddr, rf_wdata
   );

endinterface

// File: rtl/muldiv_step_core.sv
// One iteration on the {hi, lo} accumulator: right shift-add for multiply,
// left shift with restoring subtract for divide.
module muldiv_step_core import muldiv_pkg::*; (
   input  logic            is_div,
   input  logic [XLEN-1:0] operand,
   input  logic [XLEN-1:0] hi,
   input  logic [XLEN-1:0] lo,
   output logic [XLEN-1:0] hi_next,
   output logic [XLEN-1:0] lo_next
);

   logic [XLEN:0]   sum;
   logic [XLEN:0]   rem_shift;
   logic [XLEN+1:0] diff;
   logic            unused_bits;

   always_comb begin
      sum       = {1'b0, hi} + (lo[0] ? {1'b0, operand} : '0);
      rem_shift = {hi, lo[XLEN-1]};
      diff      = {1'b0, rem_shift} - {2'b00, operand};
      hi_next   = sum[XLEN:1];
      lo_next   = {sum[0], lo[XLEN-1:1]};
      if (is_div) begin
         // A clear borrow bit means the divisor fits; the partial remainder is then < divisor.
         if (!diff[XLEN+1]) begin
            hi_next = diff[XLEN-1:0];
            lo_next = {lo[XLEN-2:0], 1'b1};
         end else begin
            hi_next = rem_shift[XLEN-1:0];
            lo_next = {lo[XLEN-2:0], 1'b0};
         end
      end
   end

   assign unused_bits = rem_shift[XLEN] ^ diff[XLEN];

endmodule

// File: rtl/muldiv_writeback_unit.sv
// Iterative 16-bit MUL/MULH/DIV/REM with fixed 17-cycle latency and one-cycle register writeback.
// Define MULDIV_SIGNED_EN to honour op[2] as two's-complement select.
module muldiv_writeback_unit import muldiv_pkg::*; (
   input logic               clk,
   input logic               reset,
   muldiv_writeback_unit_if.slave bus
);

   localparam logic [3:0] LAST_COUNT = 4'(ITER - 1);

   state_t          state;
   logic [3:0]      counter;
   logic [1:0]      op_q;
   logic [AW-1:0]   rd_q;
   logic [XLEN-1:0] operand_q;
   logic [XLEN-1:0] hi_q;
   logic [XLEN-1:0] lo_q;
   logic            div0_q;
   logic [XLEN-1:0] hi_next;
   logic [XLEN-1:0] lo_next;
   logic [XLEN-1:0] a_mag;
   logic [XLEN-1:0] b_mag;
   logic [XLEN-1:0] result;
   logic [2*XLEN-1:0] product;
   logic [XLEN-1:0] quotient;
   logic [XLEN-1:0] remainder;

`ifdef MULDIV_SIGNED_EN
   logic a_neg;
   logic b_neg;
   logic neg_res_q;
   logic neg_rem_q;

   always_comb begin
      a_neg = bus.op[OP_SIGNED_BIT] & bus.rs1_data[XLEN-1];
      b_neg = bus.op[OP_SIGNED_BIT] & bus.rs2_data[XLEN-1];
      a_mag = a_neg ? -bus.rs1_data : bus.rs1_data;
      b_mag = b_neg ? -bus.rs2_data : bus.rs2_data;
   end
`else
   logic unused_op_sign;

   assign unused_op_sign = bus.op[OP_SIGNED_BIT];
   assign a_mag = bus.rs1_data;
   assign b_mag = bus.rs2_data;
`endif

   muldiv_step_core u_step (
      .is_div  (op_q[1]),
      .operand (operand_q),
      .hi      (hi_q),
      .lo      (lo_q),
      .hi_next (hi_next),
      .lo_next (lo_next)
   );

   // Result of the final iteration, selected and registered into rf_wdata on entry to DONE.
   always_comb begin
      product   = {hi_next, lo_next};
      quotient  = lo_next;
      remainder = hi_next;
`ifdef MULDIV_SIGNED_EN
      if (neg_res_q) begin
         product  = -product;
         quotient = -quotient;
      end
      if (neg_rem_q) remainder = -remainder;
`endif
      if (div0_q) quotient = DIV0_QUOTIENT;
      unique case (op_q)
         OP_MUL:  result = product[XLEN-1:0];
         OP_MULH: result = product[2*XLEN-1:XLEN];
         OP_DIV:  result = quotient;
         OP_REM:  result = remainder;
         default: result = '0;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         counter      <= '0;
         op_q         <= '0;
         rd_q         <= '0;
         operand_q    <= '0;
         hi_q         <= '0;
         lo_q         <= '0;
         div0_q       <= 1'b0;
         bus.rf_we    <= 1'b0;
         bus.rf_waddr <= '0;
         bus.rf_wdata <= '0;
`ifdef MULDIV_SIGNED_EN
         neg_res_q    <= 1'b0;
         neg_rem_q    <= 1'b0;
`endif
      end else begin
         unique case (state)
            IDLE: begin
               if (bus.start) begin
                  state     <= BUSY;
                  counter   <= '0;
                  op_q      <= bus.op[1:0];
                  rd_q      <= bus.rd;
                  operand_q <= bus.op[1] ? b_mag : a_mag;
                  hi_q      <= '0;
                  lo_q      <= bus.op[1] ? a_mag : b_mag;
                  div0_q    <= (bus.rs2_data == '0);
`ifdef MULDIV_SIGNED_EN
                  neg_res_q <= a_neg ^ b_neg;
                  neg_rem_q <= a_neg;
`endif
               end
            end
            BUSY: begin
               hi_q    <= hi_next;
               lo_q    <= lo_next;
               counter <= counter + 4'd1;
               if (counter == LAST_COUNT) begin
                  state        <= DONE;
                  bus.rf_we    <= 1'b1;
                  bus.rf_waddr <= rd_q;
                  bus.rf_wdata <= result;
               end
            end
            DONE: begin
               state     <= IDLE;
               bus.rf_we <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.stall = ((state == IDLE) && bus.start) || (state == BUSY);
   assign bus.busy  = (state != IDLE);

endmodule

// File: tb/tb_muldiv_writeback_unit.sv
// Directed bench for muldiv_writeback_unit; expectations follow MULDIV_SIGNED_EN when defined.
module tb_muldiv_writeback_unit;
   import muldiv_pkg::*;

   logic clk;
   logic reset;
   int   total;
   int   bad;

   muldiv_writeback_unit_if bus ();

   muldiv_writeback_unit dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

`ifdef MULDIV_SIGNED_EN
   localparam logic [15:0] EXP_SDIV   = 16'hFFFD;
   localparam logic [15:0] EXP_SREM   = 16'hFFFF;
   localparam logic [15:0] EXP_OVDIV  = 16'h8000;
   localparam logic [15:0] EXP_OVREM  = 16'h0000;
   localparam logic [15:0] EXP_SMULH  = 16'hFFFF;
`else
   localparam logic [15:0] EXP_SDIV   = 16'h7FFC;
   localparam logic [15:0] EXP_SREM   = 16'h0001;
   localparam logic [15:0] EXP_OVDIV  = 16'h0000;
   localparam logic [15:0] EXP_OVREM  = 16'h8000;
   localparam logic [15:0] EXP_SMULH  = 16'h0002;
`endif

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Accept at E0, scramble inputs, then watch every cycle up to and past E17.
   task automatic run_op(input string tag, input logic [2:0] op, input logic [15:0] a,
                         input logic [15:0] b, input logic [3:0] rd, input logic [15:0] exp);
      @(negedge clk);
      bus.op       = op;
      bus.rs1_data = a;
      bus.rs2_data = b;
      bus.rd       = rd;
      bus.start    = 1'b1;
      #1 check({tag, ":stall_req"}, {31'd0, bus.stall}, 32'd1);
      @(posedge clk);
      #1;
      bus.start    = 1'b0;
      bus.op       = ~op;
      bus.rs1_data = ~a;
      bus.rs2_data = ~b;
      bus.rd       = ~rd;
      for (int k = 1; k <= 17; k++) begin
         @(negedge clk);
         check($sformatf("%s:we%0d", tag, k), {31'd0, bus.rf_we}, {31'd0, k == 17});
         check($sformatf("%s:stall%0d", tag, k), {31'd0, bus.stall}, {31'd0, k != 17});
         if (k == 17) begin
            check({tag, ":waddr"}, {28'd0, bus.rf_waddr}, {28'd0, rd});
            check({tag, ":wdata"}, {16'd0, bus.rf_wdata}, {16'd0, exp});
            check({tag, ":busy_done"}, {31'd0, bus.busy}, 32'd1);
         end
         @(posedge clk);
      end
      #1;
      check({tag, ":busy_after"}, {31'd0, bus.busy}, 32'd0);
      check({tag, ":we_after"}, {31'd0, bus.rf_we}, 32'd0);
   endtask

   initial begin
      int pulses;
      total        = 0;
      bad          = 0;
      reset        = 1'b1;
      bus.start    = 1'b0;
      bus.op       = 3'b000;
      bus.rs1_data = '0;
      bus.rs2_data = '0;
      bus.rd       = '0;
      #23;
      check("rst_stall", {31'd0, bus.stall}, 32'd0);
      check("rst_busy", {31'd0, bus.busy}, 32'd0);
      check("rst_we", {31'd0, bus.rf_we}, 32'd0);
      check("rst_waddr", {28'd0, bus.rf_waddr}, 32'd0);
      check("rst_wdata", {16'd0, bus.rf_wdata}, 32'd0);
      @(negedge clk);
      reset = 1'b0;

      run_op("mul7x9", 3'b000, 16'h0007, 16'h0009, 4'd3, 16'h003F);
      run_op("mulh", 3'b001, 16'h1234, 16'h0100, 4'd5, 16'h0012);
      run_op("mul_lo", 3'b000, 16'h1234, 16'h0100, 4'd5, 16'h3400);
      run_op("div100_7", 3'b010, 16'd100, 16'd7, 4'd9, 16'h000E);
      run_op("rem100_7", 3'b011, 16'd100, 16'd7, 4'd10, 16'h0002);
      run_op("div0", 3'b010, 16'h1234, 16'h0000, 4'd1, 16'hFFFF);
      run_op("rem0", 3'b011, 16'h1234, 16'h0000, 4'd2, 16'h1234);

      // Abort after the eighth iteration edge.
      @(negedge clk);
      bus.op       = 3'b000;
      bus.rs1_data = 16'h0005;
      bus.rs2_data = 16'h0006;
      bus.rd       = 4'd7;
      bus.start    = 1'b1;
      @(posedge clk);
      #1 bus.start = 1'b0;
      repeat (8) @(posedge clk);
      #3 reset = 1'b1;
      #1;
      check("abort_busy", {31'd0, bus.busy}, 32'd0);
      check("abort_stall", {31'd0, bus.stall}, 32'd0);
      check("abort_we", {31'd0, bus.rf_we}, 32'd0);
      @(negedge clk);
      reset  = 1'b0;
      pulses = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus.rf_we) pulses++;
      end
      check("abort_no_we", pulses, 32'd0);

      run_op("mul3x4", 3'b000, 16'h0003, 16'h0004, 4'd4, 16'h000C);
      run_op("mul_rd0", 3'b000, 16'h0003, 16'h0004, 4'd0, 16'h000C);
      run_op("sdiv", 3'b110, 16'hFFF9, 16'h0002, 4'd6, EXP_SDIV);
      run_op("srem", 3'b111, 16'hFFF9, 16'h0002, 4'd6, EXP_SREM);
      run_op("ovdiv", 3'b110, 16'h8000, 16'hFFFF, 4'd8, EXP_OVDIV);
      run_op("ovrem", 3'b111, 16'h8000, 16'hFFFF, 4'd8, EXP_OVREM);
      run_op("smul", 3'b100, 16'hFFFE, 16'h0003, 4'd11, 16'hFFFA);
      run_op("smulh", 3'b101, 16'hFFFE, 16'h0003, 4'd12, EXP_SMULH);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
